// File: rtl/deb_pkg.sv
// Shared constants and level type for the multi-channel debouncer.
package deb_pkg;

  localparam int unsigned DEB_DEFAULT_STABLE = 8;
  localparam int unsigned DEB_DEFAULT_SYNC   = 2;
  localparam int unsigned DEB_DEFAULT_HOLD   = 1024;

  typedef enum logic {
    DEB_LOW  = 1'b0,
    DEB_HIGH = 1'b1
  } deb_level_e;

endpackage

// File: rtl/deb_chan.sv
// One debouncer channel: synchroniser, stability filter, edge pulses and an
// optional long-press pulse (enabled by defining DEB_HOLD_EN).
module deb_chan
  import deb_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEB_DEFAULT_STABLE,
  parameter int unsigned SYNC_STAGES   = DEB_DEFAULT_SYNC,
  parameter bit          RESET_VAL     = 1'b0
`ifdef DEB_HOLD_EN
  ,
  parameter int unsigned HOLD_CYCLES   = DEB_DEFAULT_HOLD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CNT_MAX = STABLE_CYCLES - 1;
  localparam logic        RST_LVL = RESET_VAL ? DEB_HIGH : DEB_LOW;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: out follows s only after it has differed for STABLE_CYCLES cycles.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CNT_MAX)) begin
      cnt_d  = '0;
      out_d  = s;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      cnt_q  <= '0;
      out_q  <= RST_LVL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEB_HOLD_EN
  localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              hold_q, hold_d;

  // Counter saturates at HOLD_CYCLES so each press yields a single pulse.
  always_comb begin
    hcnt_d = hcnt_q;
    hold_d = 1'b0;
    if (!out_d || rise_d) begin
      hcnt_d = '0;
    end else if (hcnt_q != HCNT_W'(HOLD_CYCLES)) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
      hold_d = (hcnt_q == HCNT_W'(HOLD_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/deb_multi.sv
// Multi-channel debouncer top: CHANNELS independent deb_chan instances plus
// an any-edge summary. Long-press pulses exist only when DEB_HOLD_EN is defined.
module deb_multi
  import deb_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = DEB_DEFAULT_STABLE,
  parameter int unsigned SYNC_STAGES   = DEB_DEFAULT_SYNC,
  parameter bit          RESET_VAL     = 1'b0,
  parameter int unsigned HOLD_CYCLES   = DEB_DEFAULT_HOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change,
  output logic [CHANNELS-1:0] hold
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("deb_multi: CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("deb_multi: STABLE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("deb_multi: SYNC_STAGES must be >= 2");
  end
`ifdef DEB_HOLD_EN
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("deb_multi: HOLD_CYCLES must be >= 1");
  end
`else
  // HOLD_CYCLES only has meaning with the long-press feature built in.
  if (HOLD_CYCLES == 0) begin : g_hold_ignored
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    deb_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_VAL    (RESET_VAL)
`ifdef DEB_HOLD_EN
      ,
      .HOLD_CYCLES  (HOLD_CYCLES)
`endif
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_deb_multi.sv
// Scoreboard bench for deb_multi: stimulus pushes expected edge events,
// a negedge monitor pops one per any_change cycle and compares.
module tb_deb_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] out, rise, fall, hold;
  logic       any_change;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];

  deb_multi #(
    .CHANNELS     (4),
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (2),
    .RESET_VAL    (1'b0),
    .HOLD_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change),
    .hold      (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input step happens at this negedge; the event lands SYNC+STABLE edges later.
  task automatic expect_evt(input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc = cyc + 10;
    e.o   = o;
    e.r   = r;
    e.f   = f;
    sb.push_back(e);
  endtask

  task automatic poll_hold(input int n, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    repeat (n) begin
      @(negedge clk);
      if (hold[0] === 1'b1) begin
        cnt++;
        at = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && any_change !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual out=%b rise=%b fall=%b required none (cyc %0d)",
                 out, rise, fall, cyc);
      end else begin
        e = sb.pop_front();
        check("evt_cycle", 32'(cyc), 32'(e.cyc));
        check("evt_out", 32'(out), 32'(e.o));
        check("evt_rise", 32'(rise), 32'(e.r));
        check("evt_fall", 32'(fall), 32'(e.f));
        check("evt_rise_fall_excl", 32'(rise & fall), 32'(0));
      end
    end
  end

  initial begin
    int hc, hat, c0;
    rst_n = 1'b0;
    in    = 4'b1111;
    idle(3);
    check("rst_out", 32'(out), 32'(0));
    check("rst_rise", 32'(rise), 32'(0));
    check("rst_fall", 32'(fall), 32'(0));
    check("rst_any", 32'(any_change), 32'(0));
    check("rst_hold", 32'(hold), 32'(0));

    // Release with all inputs high: rise on all channels after filtering.
    rst_n = 1'b1;
    expect_evt(4'b1111, 4'b1111, 4'b0000);
    idle(1);
    check("post_rst_out_low", 32'(out), 32'(0));
    idle(13);

    in = 4'b0000;
    expect_evt(4'b0000, 4'b0000, 4'b1111);
    idle(14);

    // Single clean rise on channel 0.
    in = 4'b0001;
    expect_evt(4'b0001, 4'b0001, 4'b0000);
    idle(14);

    // Bounce on channel 1: only the final stable high counts.
    in[1] = 1'b1;
    idle(5);
    in[1] = 1'b0;
    idle(1);
    in[1] = 1'b1;
    expect_evt(4'b0011, 4'b0010, 4'b0000);
    idle(14);

    // Short pulses on channel 2 are filtered out entirely.
    in[2] = 1'b1;
    idle(1);
    in[2] = 1'b0;
    idle(15);
    in[2] = 1'b1;
    idle(7);
    in[2] = 1'b0;
    idle(15);
    check("glitch_out", 32'(out), 32'(4'b0011));

    // Simultaneous rise then fall on channels 3:2.
    in[3:2] = 2'b11;
    expect_evt(4'b1111, 4'b1100, 4'b0000);
    idle(14);
    in[3:2] = 2'b00;
    expect_evt(4'b0011, 4'b0000, 4'b1100);
    idle(14);

    // Long press on channel 0, released and pressed again.
    in[0] = 1'b0;
    expect_evt(4'b0010, 4'b0000, 4'b0001);
    idle(14);
    for (int k = 0; k < 2; k++) begin
      c0 = cyc;
      in[0] = 1'b1;
      expect_evt(4'b0011, 4'b0001, 4'b0000);
      poll_hold(40, hc, hat);
`ifdef DEB_HOLD_EN
      check("hold_count", 32'(hc), 32'(1));
      check("hold_cycle", 32'(hat), 32'(c0 + 26));
`else
      check("hold_none", 32'(hc), 32'(0));
`endif
      in[0] = 1'b0;
      expect_evt(4'b0010, 4'b0000, 4'b0001);
      idle(14);
    end

    // Reset mid-count: outputs clear at once and filtering restarts.
    in = 4'b0100;
    idle(5);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'(0));
    check("midrst_rise", 32'(rise), 32'(0));
    check("midrst_fall", 32'(fall), 32'(0));
    check("midrst_any", 32'(any_change), 32'(0));
    check("midrst_hold", 32'(hold), 32'(0));
    idle(2);
    rst_n = 1'b1;
    expect_evt(4'b0100, 4'b0100, 4'b0000);
    idle(16);

    check("sb_pending", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
